// File: rtl/rob_commit_if.sv
// Port bundle for rob_commit: issue, RS/SLB writeback, operand query and commit/flush broadcast.
// The ROB itself uses the slave modport; the surrounding core (or a bench) uses master.
interface rob_commit_if #(
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
);
    logic                 rdy;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_is_jalr;
    logic [DATA_W-1:0]    issue_pc;
    logic [ROB_IDX_W-1:0] alloc_tag;
    logic                 rob_full;
    logic [ROB_IDX_W-1:0] b2;
    logic                 RS_wb_valid;
    logic [DATA_W-1:0]    ROB_s_value_b2_;
    logic [DATA_W-1:0]    ROB_s_jumppc_b2_;
    logic [ROB_IDX_W-1:0] b4;
    logic                 SLB_wb_valid;
    logic [DATA_W-1:0]    SLB_to_ROB_value;
    logic [ROB_IDX_W-1:0] query_tag;
    logic                 query_ready;
    logic [DATA_W-1:0]    query_value;
    logic                 ROB_to_RS_needchange;
    logic [ROB_IDX_W-1:0] b3;
    logic [DATA_W-1:0]    ROB_to_RS_value_b3;
    logic [4:0]           commit_rd;
    logic                 Clear_flag;
    logic [DATA_W-1:0]    clear_pc;

    modport slave (
        input  rdy, issue_valid, issue_rd, issue_is_jalr, issue_pc,
        input  b2, RS_wb_valid, ROB_s_value_b2_, ROB_s_jumppc_b2_,
        input  b4, SLB_wb_valid, SLB_to_ROB_value, query_tag,
        output alloc_tag, rob_full, query_ready, query_value,
        output ROB_to_RS_needchange, b3, ROB_to_RS_value_b3, commit_rd,
        output Clear_flag, clear_pc
    );

    modport master (
        output rdy, issue_valid, issue_rd, issue_is_jalr, issue_pc,
        output b2, RS_wb_valid, ROB_s_value_b2_, ROB_s_jumppc_b2_,
        output b4, SLB_wb_valid, SLB_to_ROB_value, query_tag,
        input  alloc_tag, rob_full, query_ready, query_value,
        input  ROB_to_RS_needchange, b3, ROB_to_RS_value_b3, commit_rd,
        input  Clear_flag, clear_pc
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, out-of-order RS/SLB writeback, in-order commit with JALR flush.
// Optional macro ROB_BYPASS_EN forwards same-cycle writebacks onto the query port.
module rob_commit #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    rob_commit_if.slave  bus
);
    localparam int CNT_W = ROB_IDX_W + 1;

    logic [ROB_IDX_W-1:0] head_reg;
    logic [ROB_IDX_W-1:0] tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [ROB_SIZE-1:0]  busy_reg;
    logic [ROB_SIZE-1:0]  ready_reg;
    logic [ROB_SIZE-1:0]  is_jalr_reg;
    logic [DATA_W-1:0]    value_mem  [ROB_SIZE];
    logic [DATA_W-1:0]    jumppc_mem [ROB_SIZE];
    logic [DATA_W-1:0]    pc_mem     [ROB_SIZE];
    logic [4:0]           rd_mem     [ROB_SIZE];

    logic                 needchange_reg;
    logic [ROB_IDX_W-1:0] b3_reg;
    logic [DATA_W-1:0]    b3_value_reg;
    logic [4:0]           commit_rd_reg;
    logic                 clear_flag_reg;
    logic [DATA_W-1:0]    clear_pc_reg;

    logic rob_full;
    logic commit_fire;
    logic flush;
    logic issue_fire;
    logic rs_wr;
    logic slb_wr;

    // Entry PC is kept for trace/debug; nothing in the datapath consumes it.
    logic [DATA_W-1:0] unused_head_pc;
    assign unused_head_pc = pc_mem[head_reg];

    assign rob_full    = (count_reg == CNT_W'(ROB_SIZE));
    assign commit_fire = bus.rdy && (count_reg != '0) && busy_reg[head_reg] && ready_reg[head_reg];
    assign flush       = commit_fire && is_jalr_reg[head_reg];
    assign issue_fire  = bus.rdy && bus.issue_valid && !rob_full && !clear_flag_reg && !flush;
    assign rs_wr       = bus.rdy && bus.RS_wb_valid && busy_reg[bus.b2] && !flush;
    // On a same-tag collision the RS result is the one that lands.
    assign slb_wr      = bus.rdy && bus.SLB_wb_valid && busy_reg[bus.b4] && !flush &&
                         !(bus.RS_wb_valid && (bus.b2 == bus.b4));

    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            localparam logic [ROB_IDX_W-1:0] IDX = ROB_IDX_W'(gi);
            logic rs_hit, slb_hit, alloc_hit, retire_hit;
            assign rs_hit     = rs_wr && (bus.b2 == IDX);
            assign slb_hit    = slb_wr && (bus.b4 == IDX);
            assign alloc_hit  = issue_fire && (tail_reg == IDX);
            assign retire_hit = commit_fire && (head_reg == IDX);

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    busy_reg[gi]    <= 1'b0;
                    ready_reg[gi]   <= 1'b0;
                    is_jalr_reg[gi] <= 1'b0;
                end else begin
                    if (alloc_hit) begin
                        busy_reg[gi]    <= 1'b1;
                        ready_reg[gi]   <= 1'b0;
                        is_jalr_reg[gi] <= bus.issue_is_jalr;
                    end else if (retire_hit) begin
                        busy_reg[gi] <= 1'b0;
                    end
                    if (rs_hit || slb_hit) begin
                        ready_reg[gi] <= 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rs_hit) begin
                    value_mem[gi] <= bus.ROB_s_value_b2_;
                    if (is_jalr_reg[gi]) jumppc_mem[gi] <= bus.ROB_s_jumppc_b2_;
                end else if (slb_hit) begin
                    value_mem[gi] <= bus.SLB_to_ROB_value;
                    if (is_jalr_reg[gi]) jumppc_mem[gi] <= bus.SLB_to_ROB_value;
                end
                if (alloc_hit) begin
                    rd_mem[gi] <= bus.issue_rd;
                    pc_mem[gi] <= bus.issue_pc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            needchange_reg <= 1'b0;
            b3_reg         <= '0;
            b3_value_reg   <= '0;
            commit_rd_reg  <= '0;
            clear_flag_reg <= 1'b0;
            clear_pc_reg   <= '0;
        end else if (bus.rdy) begin
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (commit_fire) head_reg <= head_reg + 1'b1;
                if (issue_fire)  tail_reg <= tail_reg + 1'b1;
                count_reg <= count_reg + CNT_W'(issue_fire) - CNT_W'(commit_fire);
            end
            needchange_reg <= commit_fire && (rd_mem[head_reg] != 5'd0);
            commit_rd_reg  <= commit_fire ? rd_mem[head_reg] : 5'd0;
            if (commit_fire) begin
                b3_reg       <= head_reg;
                b3_value_reg <= value_mem[head_reg];
            end
            clear_flag_reg <= flush;
            if (flush) clear_pc_reg <= jumppc_mem[head_reg];
        end
    end

    always_comb begin
        bus.query_ready = busy_reg[bus.query_tag] && ready_reg[bus.query_tag];
        bus.query_value = value_mem[bus.query_tag];
`ifdef ROB_BYPASS_EN
        if (bus.RS_wb_valid && (bus.b2 == bus.query_tag) && busy_reg[bus.query_tag]) begin
            bus.query_ready = 1'b1;
            bus.query_value = bus.ROB_s_value_b2_;
        end else if (bus.SLB_wb_valid && (bus.b4 == bus.query_tag) && busy_reg[bus.query_tag]) begin
            bus.query_ready = 1'b1;
            bus.query_value = bus.SLB_to_ROB_value;
        end
`endif
    end

    assign bus.alloc_tag            = tail_reg;
    assign bus.rob_full             = rob_full;
    assign bus.ROB_to_RS_needchange = needchange_reg;
    assign bus.b3                   = b3_reg;
    assign bus.ROB_to_RS_value_b3   = b3_value_reg;
    assign bus.commit_rd            = commit_rd_reg;
    assign bus.Clear_flag           = clear_flag_reg;
    assign bus.clear_pc             = clear_pc_reg;
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: queue-based ROB model checked every cycle, plus directed literal checks.
module tb_rob_commit;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_commit_if #(.ROB_IDX_W(4), .DATA_W(32)) bus ();

    rob_commit #(.ROB_SIZE(N), .ROB_IDX_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the ROB as an ordered queue of live tags (oldest first) plus per-tag payload.
    int          mq[$];
    int          m_tail;
    bit          m_ready [N];
    logic [31:0] m_val   [N];
    logic [31:0] m_jpc   [N];
    int          m_rd    [N];
    bit          m_jalr  [N];
    bit          model_live = 1'b0;
    bit          e_need, e_clr;
    int          e_b3, e_crd;
    logic [31:0] e_val, e_cpc;

    function automatic bit in_q(int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_tail = 0;
            for (int i = 0; i < N; i++) m_ready[i] = 1'b0;
            e_need = 0; e_clr = 0; e_b3 = 0; e_crd = 0; e_val = 0; e_cpc = 0;
            model_live = 1'b1;
        end else if (model_live && bus.rdy) begin
            bit commit, jal, issue_ok;
            int hd;
            commit   = (mq.size() > 0) && m_ready[mq[0]];
            hd       = commit ? mq[0] : 0;
            jal      = commit && m_jalr[hd];
            issue_ok = bus.issue_valid && (mq.size() < N) && !e_clr && !jal;
            e_need   = commit && (m_rd[hd] != 0);
            e_crd    = commit ? m_rd[hd] : 0;
            if (commit) begin
                e_b3  = hd;
                e_val = m_val[hd];
            end
            e_clr = jal;
            if (jal) e_cpc = m_jpc[hd];
            if (jal) begin
                mq.delete();
                m_tail = 0;
                for (int i = 0; i < N; i++) m_ready[i] = 1'b0;
            end else begin
                if (bus.RS_wb_valid && in_q(int'(bus.b2))) begin
                    m_val[bus.b2] = bus.ROB_s_value_b2_;
                    if (m_jalr[bus.b2]) m_jpc[bus.b2] = bus.ROB_s_jumppc_b2_;
                    m_ready[bus.b2] = 1'b1;
                end
                if (bus.SLB_wb_valid && in_q(int'(bus.b4)) &&
                    !(bus.RS_wb_valid && bus.b2 == bus.b4)) begin
                    m_val[bus.b4] = bus.SLB_to_ROB_value;
                    if (m_jalr[bus.b4]) m_jpc[bus.b4] = bus.SLB_to_ROB_value;
                    m_ready[bus.b4] = 1'b1;
                end
                if (commit) void'(mq.pop_front());
                if (issue_ok) begin
                    mq.push_back(m_tail);
                    m_ready[m_tail] = 1'b0;
                    m_rd[m_tail]    = int'(bus.issue_rd);
                    m_jalr[m_tail]  = bus.issue_is_jalr;
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live && !rst) begin
            bit          q_rdy;
            logic [31:0] q_val;
            int          qt;
            qt    = int'(bus.query_tag);
            q_rdy = in_q(qt) && m_ready[qt];
            q_val = m_val[qt];
`ifdef ROB_BYPASS_EN
            if (bus.RS_wb_valid && bus.b2 == bus.query_tag && in_q(qt)) begin
                q_rdy = 1'b1; q_val = bus.ROB_s_value_b2_;
            end else if (bus.SLB_wb_valid && bus.b4 == bus.query_tag && in_q(qt)) begin
                q_rdy = 1'b1; q_val = bus.SLB_to_ROB_value;
            end
`endif
            chk("m_alloc_tag", 32'(bus.alloc_tag), 32'(m_tail));
            chk("m_rob_full", 32'(bus.rob_full), 32'(mq.size() == N));
            chk("m_needchange", 32'(bus.ROB_to_RS_needchange), 32'(e_need));
            chk("m_b3", 32'(bus.b3), 32'(e_b3));
            chk("m_b3_value", bus.ROB_to_RS_value_b3, e_val);
            chk("m_commit_rd", 32'(bus.commit_rd), 32'(e_crd));
            chk("m_clear_flag", 32'(bus.Clear_flag), 32'(e_clr));
            if (e_clr) chk("m_clear_pc", bus.clear_pc, e_cpc);
            chk("m_query_ready", 32'(bus.query_ready), 32'(q_rdy));
            if (q_rdy) chk("m_query_value", bus.query_value, q_val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.issue_valid   = 1'b0;
        bus.issue_is_jalr = 1'b0;
        bus.RS_wb_valid   = 1'b0;
        bus.SLB_wb_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(int rd, bit jalr, logic [31:0] pc);
        bus.issue_valid   = 1'b1;
        bus.issue_rd      = 5'(rd);
        bus.issue_is_jalr = jalr;
        bus.issue_pc      = pc;
        tick();
    endtask

    task automatic rs_set(int tag, logic [31:0] val, logic [31:0] jpc);
        bus.RS_wb_valid      = 1'b1;
        bus.b2               = 4'(tag);
        bus.ROB_s_value_b2_  = val;
        bus.ROB_s_jumppc_b2_ = jpc;
    endtask

    task automatic slb_set(int tag, logic [31:0] val);
        bus.SLB_wb_valid     = 1'b1;
        bus.b4               = 4'(tag);
        bus.SLB_to_ROB_value = val;
    endtask

    task automatic query(int tag, bit rdy_exp, logic [31:0] val_exp, string name);
        bus.query_tag = 4'(tag);
        #1;
        chk({name, "_ready"}, 32'(bus.query_ready), 32'(rdy_exp));
        if (rdy_exp) chk({name, "_value"}, bus.query_value, val_exp);
    endtask

    initial begin
        bus.rdy = 1'b1;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_is_jalr = 0; bus.issue_pc = 0;
        bus.b2 = 0; bus.RS_wb_valid = 0; bus.ROB_s_value_b2_ = 0; bus.ROB_s_jumppc_b2_ = 0;
        bus.b4 = 0; bus.SLB_wb_valid = 0; bus.SLB_to_ROB_value = 0; bus.query_tag = 0;

        // Reset and in-order commit of out-of-order results.
        do_reset();
        chk("rst_alloc_tag", 32'(bus.alloc_tag), 0);
        chk("rst_full", 32'(bus.rob_full), 0);
        chk("rst_needchange", 32'(bus.ROB_to_RS_needchange), 0);
        chk("rst_clear_flag", 32'(bus.Clear_flag), 0);
        chk("rst_commit_rd", 32'(bus.commit_rd), 0);
        chk("rst_b3", 32'(bus.b3), 0);
        issue(1, 0, 32'h100); chk("a_alloc1", 32'(bus.alloc_tag), 1);
        issue(2, 0, 32'h104); chk("a_alloc2", 32'(bus.alloc_tag), 2);
        issue(3, 0, 32'h108); chk("a_alloc3", 32'(bus.alloc_tag), 3);
        chk("a_full", 32'(bus.rob_full), 0);
        rs_set(1, 32'h11, 0); tick();
        chk("a_no_commit", 32'(bus.ROB_to_RS_needchange), 0);
        query(1, 1, 32'h11, "a_q1");
        rs_set(0, 32'h10, 0); tick();
        chk("a_wb_edge_no_commit", 32'(bus.ROB_to_RS_needchange), 0);
        tick();
        chk("a_c0_need", 32'(bus.ROB_to_RS_needchange), 1);
        chk("a_c0_b3", 32'(bus.b3), 0);
        chk("a_c0_val", bus.ROB_to_RS_value_b3, 32'h10);
        chk("a_c0_rd", 32'(bus.commit_rd), 1);
        tick();
        chk("a_c1_need", 32'(bus.ROB_to_RS_needchange), 1);
        chk("a_c1_b3", 32'(bus.b3), 1);
        chk("a_c1_val", bus.ROB_to_RS_value_b3, 32'h11);
        chk("a_c1_rd", 32'(bus.commit_rd), 2);
        tick();
        chk("a_idle_need", 32'(bus.ROB_to_RS_needchange), 0);
        chk("a_idle_b3_hold", 32'(bus.b3), 1);

        // Fill to full, overflow issue, wrap of tail with simultaneous commit and issue.
        do_reset();
        for (int i = 0; i < N; i++) issue(i + 1, 0, 32'h200 + 32'(4 * i));
        chk("b_full", 32'(bus.rob_full), 1);
        chk("b_alloc_wrap", 32'(bus.alloc_tag), 0);
        issue(20, 0, 32'h300);
        chk("b_ovf_full", 32'(bus.rob_full), 1);
        chk("b_ovf_alloc", 32'(bus.alloc_tag), 0);
        rs_set(0, 32'h30, 0); tick();
        tick();
        chk("b_c0_need", 32'(bus.ROB_to_RS_needchange), 1);
        chk("b_not_full", 32'(bus.rob_full), 0);
        rs_set(1, 32'h31, 0); tick();
        issue(7, 0, 32'h400);
        chk("b_ci_b3", 32'(bus.b3), 1);
        chk("b_ci_val", bus.ROB_to_RS_value_b3, 32'h31);
        chk("b_ci_alloc", 32'(bus.alloc_tag), 1);
        chk("b_ci_full", 32'(bus.rob_full), 0);
        issue(8, 0, 32'h404);
        chk("b_refull", 32'(bus.rob_full), 1);
        chk("b_refull_alloc", 32'(bus.alloc_tag), 2);

        // Dual writeback, bypass window, non-busy writeback, rdy hold.
        do_reset();
        for (int i = 0; i < 8; i++) issue(i + 1, 0, 32'h500 + 32'(4 * i));
        rs_set(5, 32'hAB, 0);
        slb_set(6, 32'h66);
`ifdef ROB_BYPASS_EN
        query(5, 1, 32'hAB, "c_bypass");
`else
        query(5, 0, 32'h0, "c_nobypass");
`endif
        tick();
        query(5, 1, 32'hAB, "c_q5");
        query(6, 1, 32'h66, "c_q6");
        rs_set(9, 32'h99, 0); tick();
        query(9, 0, 32'h0, "c_q9");
        bus.rdy = 1'b0;
        rs_set(7, 32'h77, 0); tick();
        query(7, 0, 32'h0, "c_hold_q7");
        bus.rdy = 1'b1;
        rs_set(7, 32'h77, 0); tick();
        query(7, 1, 32'h77, "c_q7");
        chk("c_need", 32'(bus.ROB_to_RS_needchange), 0);

        // JALR commit flushes the ROB and redirects.
        do_reset();
        issue(1, 0, 32'h100);
        issue(5, 1, 32'h104);
        issue(6, 0, 32'h108);
        slb_set(0, 32'h10);
        rs_set(1, 32'h108, 32'h1000);
        tick();
        tick();
        chk("d_c0_b3", 32'(bus.b3), 0);
        chk("d_c0_clr", 32'(bus.Clear_flag), 0);
        rs_set(2, 32'h77, 0); tick();
        chk("d_clr", 32'(bus.Clear_flag), 1);
        chk("d_clr_pc", bus.clear_pc, 32'h1000);
        chk("d_jalr_b3", 32'(bus.b3), 1);
        chk("d_jalr_val", bus.ROB_to_RS_value_b3, 32'h108);
        chk("d_jalr_rd", 32'(bus.commit_rd), 5);
        chk("d_alloc0", 32'(bus.alloc_tag), 0);
        issue(9, 0, 32'h600);
        chk("d_clr_drop", 32'(bus.Clear_flag), 0);
        chk("d_issue_ignored", 32'(bus.alloc_tag), 0);
        query(2, 0, 32'h0, "d_q2");
        issue(9, 0, 32'h600);
        chk("d_alloc1", 32'(bus.alloc_tag), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
